// File: rtl/debug_mailbox.sv
// -----------------------------------------------------------------------------
// debug_mailbox
//
// Purpose:
//   8-word debug argument RAM. The core stores arguments to words 1..N_ARGS-1
//   and then stores a function code to word 0. The word-0 store snapshots all
//   words into a command buffer, which is offered to a consumer over a
//   valid/ready handshake. The snapshot is held stable until it is accepted,
//   so the consumer never sees half-updated arguments.
//
// Handshake:
//   cmd_valid/datas are registered. A command transfers on any rising edge
//   where cmd_valid=1 and cmd_ready=1. While cmd_valid=1, datas does not
//   change until after that edge. cmd_ready is ignored when cmd_valid=0.
//
// Configuration macro:
//   DEBUG_MAILBOX_FIFO_EN - when defined, the command buffer is a 2-entry
//   FIFO (datas shows the head). When undefined, a single snapshot register
//   is used and no FIFO storage exists.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   we         in   store enable
//   addr       in   word index of the store / load
//   wd         in   store data
//   rd         out  combinational read of live[addr] (0 if addr >= N_ARGS)
//   datas      out  head snapshot, word i at bits [i*32 +: 32]
//   cmd_valid  out  a snapshot is pending
//   cmd_ready  in   consumer accepts the head snapshot
//   stall      out  combinational; the core must hold its word-0 store
//   cmd_count  out  number of accepted commands (wraps)
//   dbg_state  out  buffer state: 0 idle, 1 one pending, 2 full (FIFO only)
// -----------------------------------------------------------------------------
module debug_mailbox #(
    parameter int N_ARGS = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wd,
    output logic [31:0]           rd,
    output logic [N_ARGS*32-1:0]  datas,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  stall,
    output logic [CNT_W-1:0]      cmd_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] N_ARGS_W = (ADDR_W+1)'(N_ARGS);

    state_t             r_state;
    logic               r_cmd_valid;
    logic [CNT_W-1:0]   r_cmd_count;
    logic [31:0]        r_live [N_ARGS];

    logic w_fn_req;
    logic w_fn_store;
    logic w_handshake;
    logic w_buf_full;
    logic w_addr_ok;

    assign w_fn_req    = we & (addr == '0);
    assign w_handshake = r_cmd_valid & cmd_ready;
`ifdef DEBUG_MAILBOX_FIFO_EN
    assign w_buf_full  = (r_state == S_FULL);
`else
    assign w_buf_full  = (r_state == S_PENDING);
`endif
    // A full buffer can still take a store when the head is popped this cycle.
    assign stall       = w_fn_req & w_buf_full & ~cmd_ready;
    assign w_fn_store  = w_fn_req & ~stall;

    assign w_addr_ok   = ({1'b0, addr} < N_ARGS_W);
    assign rd          = w_addr_ok ? r_live[addr] : 32'h0;

    assign cmd_valid   = r_cmd_valid;
    assign cmd_count   = r_cmd_count;
    assign dbg_state   = r_state;

    // Live bank. Word 0 only updates on an accepted function store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ARGS; i++) r_live[i] <= '0;
        end else begin
            if (w_fn_store) r_live[0] <= wd;
            for (int i = 1; i < N_ARGS; i++) begin
                if (we && (addr == ADDR_W'(i))) r_live[i] <= wd;
            end
        end
    end

`ifdef DEBUG_MAILBOX_FIFO_EN
    logic [31:0] r_fifo [2][N_ARGS];
    logic        r_wr_ptr;
    logic        r_rd_ptr;

    // When full, a push overwrites the slot being popped in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < 2; e++)
                for (int i = 0; i < N_ARGS; i++) r_fifo[e][i] <= '0;
        end else if (w_fn_store) begin
            r_fifo[r_wr_ptr][0] <= wd;
            for (int i = 1; i < N_ARGS; i++) r_fifo[r_wr_ptr][i] <= r_live[i];
        end
    end

    always_comb begin
        datas = '0;
        for (int i = 0; i < N_ARGS; i++) datas[i*32 +: 32] = r_fifo[r_rd_ptr][i];
    end
`else
    logic [31:0] r_snap [N_ARGS];

    // Word 0 takes the new store data; the rest take their pre-edge live value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ARGS; i++) r_snap[i] <= '0;
        end else if (w_fn_store) begin
            r_snap[0] <= wd;
            for (int i = 1; i < N_ARGS; i++) r_snap[i] <= r_live[i];
        end
    end

    always_comb begin
        datas = '0;
        for (int i = 0; i < N_ARGS; i++) datas[i*32 +: 32] = r_snap[i];
    end
`endif

    // Buffer occupancy FSM with registered cmd_valid and command counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_count <= '0;
`ifdef DEBUG_MAILBOX_FIFO_EN
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
`endif
        end else begin
            if (w_handshake) r_cmd_count <= r_cmd_count + CNT_W'(1);
`ifdef DEBUG_MAILBOX_FIFO_EN
            if (w_fn_store)  r_wr_ptr <= ~r_wr_ptr;
            if (w_handshake) r_rd_ptr <= ~r_rd_ptr;
            case (r_state)
                S_IDLE: begin
                    if (w_fn_store) begin
                        r_state     <= S_PENDING;
                        r_cmd_valid <= 1'b1;
                    end
                end
                S_PENDING: begin
                    if (w_fn_store && !w_handshake) begin
                        r_state <= S_FULL;
                    end else if (w_handshake && !w_fn_store) begin
                        r_state     <= S_IDLE;
                        r_cmd_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    if (w_handshake && !w_fn_store) r_state <= S_PENDING;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
`else
            case (r_state)
                S_IDLE: begin
                    if (w_fn_store) begin
                        r_state     <= S_PENDING;
                        r_cmd_valid <= 1'b1;
                    end
                end
                S_PENDING: begin
                    // A store in PENDING implies cmd_ready=1, so it replaces
                    // the command being accepted and the state is held.
                    if (w_handshake && !w_fn_store) begin
                        r_state     <= S_IDLE;
                        r_cmd_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_debug_mailbox.sv
module tb_debug_mailbox;
  localparam int N = 8;
`ifdef DEBUG_MAILBOX_FIFO_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic           we;
  logic [2:0]     addr;
  logic [31:0]    wd;
  logic [31:0]    rd;
  logic [N*32-1:0] datas;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           stall;
  logic [15:0]    cmd_count;
  logic [1:0]     dbg_state;

  debug_mailbox dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .datas     (datas),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .stall     (stall),
    .cmd_count (cmd_count),
    .dbg_state (dbg_state)
  );

  // reference model: live words, queue of pending commands, accept count
  logic [31:0]    m_live [N];
  logic [N*32-1:0] exp_q[$];
  logic [15:0]    m_count;
  int checks;
  int errors;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_live[i] = '0;
    exp_q.delete();
    m_count = '0;
  endtask

  function automatic logic [N*32-1:0] pack_cmd(input logic [31:0] w0);
    logic [N*32-1:0] c;
    c = '0;
    c[31:0] = w0;
    for (int i = 1; i < N; i++) c[i*32 +: 32] = m_live[i];
    return c;
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [N*32-1:0] obs, input logic [N*32-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle of stimulus, checked at the falling edge
  task automatic cycle(input logic w, input logic [2:0] a, input logic [31:0] d, input logic rdy);
    logic exp_stall;
    logic hs;
    we = w; addr = a; wd = d; cmd_ready = rdy;
    @(negedge clk);
    exp_stall = w && (a == 3'd0) && (exp_q.size() == CAP) && !rdy;
    chk("stall", stall, exp_stall);
    chk("rd", rd, m_live[a]);
    chk("cmd_valid", cmd_valid, exp_q.size() != 0);
    chk("cmd_count", cmd_count, m_count);
    if (exp_q.size() != 0) chk("datas", datas, exp_q[0]);
    @(posedge clk);
    hs = (exp_q.size() != 0) && rdy;
    if (hs) begin
      void'(exp_q.pop_front());
      m_count++;
    end
    if (w && a != 3'd0) m_live[a] = d;
    if (w && a == 3'd0 && !exp_stall) begin
      exp_q.push_back(pack_cmd(d));
      m_live[0] = d;
    end
    #1;
  endtask

  initial begin
    logic [N*32-1:0] e;
    logic [15:0] c0;
    logic w;
    logic [2:0] a;
    logic rdy;
    checks = 0;
    errors = 0;
    we = 0; addr = 0; wd = 0; cmd_ready = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // reset state; a word-0 request while idle must not stall
    we = 1; addr = 0;
    @(negedge clk);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_count", cmd_count, 16'd0);
    chk("rst_datas", datas, '0);
    chk("rst_stall", stall, 1'b0);
    we = 0;
    @(posedge clk); #1;

    // first command
    cycle(1, 3'd1, 32'h20, 0);
    cycle(1, 3'd0, 32'hFFFF0000, 0);
    cycle(0, 3'd1, 32'h0, 0);
    e = '0; e[31:0] = 32'hFFFF0000; e[63:32] = 32'h20;
    chk("tp1_datas", datas, e);
    chk("tp1_rd", rd, 32'h20);

    // blocked second function store, then release
    repeat (3) cycle(1, 3'd0, 32'h1, 0);
    cycle(1, 3'd0, 32'h1, 1);
    cycle(0, 3'd0, 32'h0, 0);
    chk("tp2_d0", datas[31:0], 32'h1);
    chk("tp2_valid", cmd_valid, 1'b1);
    chk("tp2_count", cmd_count, 16'd1);

    // argument stores while pending never stall
    for (int i = 1; i < N; i++) cycle(1, 3'(i), 32'(1) << i, 0);
    repeat (2) cycle(0, 3'd0, 32'h0, 1);
    cycle(1, 3'd0, 32'h2, 0);
    cycle(0, 3'd0, 32'h0, 0);
    e = '0; e[31:0] = 32'h2;
    for (int i = 1; i < N; i++) e[i*32 +: 32] = 32'(1) << i;
    chk("tp3_datas", datas, e);

    // ready held high: store at handshake edge, then single-cycle pulse
    c0 = cmd_count;
    cycle(1, 3'd0, 32'h0, 1);
    cycle(0, 3'd0, 32'h0, 1);
    cycle(0, 3'd0, 32'h0, 1);
    chk("tp4_count", cmd_count, c0 + 16'd2);
    chk("tp4_idle", cmd_valid, 1'b0);
    cycle(1, 3'd0, 32'h5, 0);
    cycle(1, 3'd0, 32'h6, 1);
    cycle(0, 3'd0, 32'h0, 0);
    repeat (2) cycle(0, 3'd0, 32'h0, 1);

    // buffer depth and ordering
    cycle(1, 3'd0, 32'h1, 0);
    cycle(1, 3'd0, 32'h2, 0);
    cycle(1, 3'd0, 32'h3, 0);
    repeat (3) cycle(0, 3'd0, 32'h0, 1);

    // asynchronous reset while a command is pending
    cycle(1, 3'd0, 32'h9, 0);
    #2 reset = 1'b0;
    we = 0;
    #1;
    chk("arst_valid", cmd_valid, 1'b0);
    chk("arst_datas", datas, '0);
    chk("arst_count", cmd_count, 16'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;

    // randomized traffic against the model
    repeat (400) begin
      w   = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      rdy = 1'($urandom_range(0, 2) != 0);
      cycle(w, a, $urandom, rdy);
    end
    repeat (3) cycle(0, 3'd0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
